sprite_layer_renderer: RTL and testbench
========================================

# sprite_layer_renderer

Parametrised VGA pixel renderer that composites a scaled, palettised background with one movable, animated, optionally mirrored sprite, then outputs 4-bit-per-channel RGB. It sits between the VGA controller (DrawX, DrawY, blank, frame_start) and the video DAC, drives two external synchronous ROMs (background and sprite sheet), and owns a runtime-writable colour palette. It supersedes the fixed-size single-image renderer.

## Interface
- IDX_W, 4: palette index width; palette has 2^IDX_W entries of 12 bits.
- BG_W, 40: background image width in texels.
- BG_SHIFT, 4: background texel = 2^BG_SHIFT × 2^BG_SHIFT screen pixels.
- BG_ADDR_W, 11: background ROM address width.
- SPR_W, 16 / SPR_H, 16: sprite frame size in texels.
- SPR_SHIFT, 1: sprite texel = 2^SPR_SHIFT screen pixels per axis.
- ANIM_FRAMES, 4: frames stored consecutively in sprite ROM.
- ANIM_DIV, 8: frame_start pulses per animation step.
- SPR_ADDR_W, 10: sprite ROM address width.
- TRANSP_IDX, 0: sprite index treated as transparent.

- vga_clk  in  1  pixel clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- blank  in  1  1 = active video (pixel displayable).
- frame_start  in  1  one-cycle pulse at start of each frame.
- sprite_x, sprite_y  in  10 each  requested sprite top-left, screen pixels.
- sprite_flip  in  1  requested horizontal mirror.
- sprite_en  in  1  requested sprite visibility.
- pal_we  in  1  palette write strobe.
- pal_addr  in  IDX_W  palette write index.
- pal_data  in  12  {R[11:8], G[7:4], B[3:0]}.
- bg_rom_addr  out  BG_ADDR_W  combinational background ROM address.
- bg_rom_q  in  IDX_W  background ROM data, 1 cycle after address.
- spr_rom_addr  out  SPR_ADDR_W  combinational sprite ROM address.
- spr_rom_q  in  IDX_W  sprite ROM data, 1 cycle after address.
- red, green, blue  out  4 each  registered pixel colour.

## Operation
- Shadow registers: sprite_x/y, sprite_flip, sprite_en are latched into active registers only on frame_start. Mid-frame changes are invisible until the next frame (no tearing). Reset value: 0, 0, 0, 0.
- Animation: div_cnt (width clog2(ANIM_DIV)) increments on each frame_start. On wrap ANIM_DIV-1→0, anim_frame increments modulo ANIM_FRAMES (ANIM_FRAMES-1→0). Both reset to 0.
- Background address: (DrawX>>BG_SHIFT) + (DrawY>>BG_SHIFT)*BG_W, truncated to BG_ADDR_W.
- Sprite hit (stage 0, combinational): dx=DrawX−act_x and dy=DrawY−act_y, 11-bit signed, each ≥0. Also require dx < SPR_W<<SPR_SHIFT, dy < SPR_H<<SPR_SHIFT, and act_en=1.
- Sprite address: u=dx>>SPR_SHIFT, v=dy>>SPR_SHIFT. If act_flip, u=SPR_W−1−u. spr_rom_addr = anim_frame*SPR_W*SPR_H + v*SPR_W + u. When not hit, spr_rom_addr is don't-care (drive 0).
- Stage 1 (registered from stage 0): hit_d, blank_d. Select idx = spr_rom_q if hit_d && spr_rom_q≠TRANSP_IDX, else bg_rom_q.
- Palette: 2^IDX_W × 12 register array, all 0 at reset. Write on pal_we is visible to reads from the next cycle; same-cycle read of the written entry returns the old value.
- Output (stage 2): if blank_d, {red,green,blue} ← palette[idx]; else 0.

## Timing
- Latency DrawX/DrawY/blank → RGB: 2 vga_clk cycles, fixed, independent of hit/flip/animation.
- ROM addresses are combinational from inputs; ROMs must return data in exactly 1 cycle.
- frame_start coincident with a pixel: that pixel still uses the old active registers; the new values apply from the next cycle.
- reset_n low: red/green/blue=0 immediately; all pipeline, shadow, animation and palette state cleared. Rendering resumes 2 cycles after release.
- Right/bottom clipping is implicit: pixels beyond 639/479 are never requested.

## Test plan
- Reset: assert reset_n=0 mid-line → RGB=0 at once; after release with palette all 0 → RGB=0.
- Palette write idx 3 = 12'hF80, bg_rom_q=3, blank=1 → RGB (F,8,0) 2 cycles after the pixel. With blank=0 → (0,0,0).
- Sprite at (100,50), en=1, SHIFT=1: DrawX=100,DrawY=50 → spr_rom_addr=0. DrawX=131 → addr=15. DrawX=132 → no hit, bg colour.
- Flip=1 at the same position: DrawX=100 → addr=15. sprite_x changed mid-frame → no effect until the next frame_start.
- Transparency: spr_rom_q=0 at hit → bg colour. spr_rom_q=5 → palette[5].
- Animation: 8 frame_start pulses → addr base 256. 32 pulses → base returns to 0.

Source files
------------

// File: rtl/sprite_layer_renderer.sv
// Composites a scaled palettised background with one animated, mirrorable sprite.
// Two-stage pipeline: ROM fetch + hit/blank delay, then palette lookup into RGB registers.
module sprite_layer_renderer #(
    parameter int IDX_W      = 4,
    parameter int BG_W       = 40,
    parameter int BG_SHIFT   = 4,
    parameter int BG_ADDR_W  = 11,
    parameter int SPR_W      = 16,
    parameter int SPR_H      = 16,
    parameter int SPR_SHIFT  = 1,
    parameter int ANIM_FRAMES = 4,
    parameter int ANIM_DIV   = 8,
    parameter int SPR_ADDR_W = 10,
    parameter int TRANSP_IDX = 0
) (
    input  logic                  vga_clk,
    input  logic                  reset_n,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    input  logic                  blank,
    input  logic                  frame_start,
    input  logic [9:0]            sprite_x,
    input  logic [9:0]            sprite_y,
    input  logic                  sprite_flip,
    input  logic                  sprite_en,
    input  logic                  pal_we,
    input  logic [IDX_W-1:0]      pal_addr,
    input  logic [11:0]           pal_data,
    output logic [BG_ADDR_W-1:0]  bg_rom_addr,
    input  logic [IDX_W-1:0]      bg_rom_q,
    output logic [SPR_ADDR_W-1:0] spr_rom_addr,
    input  logic [IDX_W-1:0]      spr_rom_q,
    output logic [3:0]            red,
    output logic [3:0]            green,
    output logic [3:0]            blue
);

    localparam int          PAL_N     = 2 ** IDX_W;
    localparam int          DIV_W     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int          FRAME_W   = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [31:0] SPR_PX_W  = 32'(SPR_W << SPR_SHIFT);
    localparam logic [31:0] SPR_PX_H  = 32'(SPR_H << SPR_SHIFT);

    logic [9:0]          r_act_x;
    logic [9:0]          r_act_y;
    logic                r_act_flip;
    logic                r_act_en;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [FRAME_W-1:0]  r_anim_frame;
    logic                r_hit_d;
    logic                r_blank_d;
    logic [11:0]         r_rgb;
    logic [11:0]         r_palette [PAL_N];

    logic [10:0]         w_dx;
    logic [10:0]         w_dy;
    logic [10:0]         w_u;
    logic [10:0]         w_v;
    logic [10:0]         w_u_f;
    logic                w_hit;
    logic [IDX_W-1:0]    w_idx;

    // Active sprite state only moves at frame boundaries so a frame never tears.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_act_x      <= '0;
            r_act_y      <= '0;
            r_act_flip   <= 1'b0;
            r_act_en     <= 1'b0;
            r_div_cnt    <= '0;
            r_anim_frame <= '0;
        end else if (frame_start) begin
            r_act_x    <= sprite_x;
            r_act_y    <= sprite_y;
            r_act_flip <= sprite_flip;
            r_act_en   <= sprite_en;
            if (r_div_cnt == DIV_W'(ANIM_DIV - 1)) begin
                r_div_cnt    <= '0;
                r_anim_frame <= (r_anim_frame == FRAME_W'(ANIM_FRAMES - 1)) ? '0 : r_anim_frame + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    assign bg_rom_addr = BG_ADDR_W'(DrawX >> BG_SHIFT)
                       + BG_ADDR_W'(DrawY >> BG_SHIFT) * BG_ADDR_W'(BG_W);

    // Differences wrap negative into bit 10, which rejects pixels left of/above the sprite.
    assign w_dx  = {1'b0, DrawX} - {1'b0, r_act_x};
    assign w_dy  = {1'b0, DrawY} - {1'b0, r_act_y};
    assign w_hit = r_act_en && !w_dx[10] && !w_dy[10]
                && ({21'd0, w_dx} < SPR_PX_W) && ({21'd0, w_dy} < SPR_PX_H);

    assign w_u   = w_dx >> SPR_SHIFT;
    assign w_v   = w_dy >> SPR_SHIFT;
    assign w_u_f = r_act_flip ? (11'(SPR_W - 1) - w_u) : w_u;

    assign spr_rom_addr = w_hit ? (SPR_ADDR_W'(r_anim_frame) * SPR_ADDR_W'(SPR_W * SPR_H)
                                 + SPR_ADDR_W'(w_v) * SPR_ADDR_W'(SPR_W)
                                 + SPR_ADDR_W'(w_u_f))
                                : '0;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_d   <= 1'b0;
            r_blank_d <= 1'b0;
        end else begin
            r_hit_d   <= w_hit;
            r_blank_d <= blank;
        end
    end

    assign w_idx = (r_hit_d && (spr_rom_q != IDX_W'(TRANSP_IDX))) ? spr_rom_q : bg_rom_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PAL_N; i++) begin
                r_palette[i] <= '0;
            end
        end else if (pal_we) begin
            r_palette[pal_addr] <= pal_data;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= r_blank_d ? r_palette[w_idx] : 12'h000;
        end
    end

    assign red   = r_rgb[11:8];
    assign green = r_rgb[7:4];
    assign blue  = r_rgb[3:0];

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Randomised bench for sprite_layer_renderer with external ROM models and a
// frame-level reference model of compositing, animation and palette behaviour.
module tb_sprite_layer_renderer;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        blank = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  sprite_x = '0;
    logic [9:0]  sprite_y = '0;
    logic        sprite_flip = 1'b0;
    logic        sprite_en = 1'b0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_addr = '0;
    logic [11:0] pal_data = '0;
    logic [10:0] bg_rom_addr;
    logic [3:0]  bg_rom_q = '0;
    logic [9:0]  spr_rom_addr;
    logic [3:0]  spr_rom_q = '0;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;

    logic [3:0]  bgMem  [2048];
    logic [3:0]  sprMem [1024];

    int          testsRun = 0;
    int          testsFailed = 0;

    int          mActX, mActY, mFs;
    bit          mActFlip, mActEn;
    logic [11:0] mPal [16];
    bit          prevBlank;
    logic [3:0]  prevIdx;

    sprite_layer_renderer dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start), .sprite_x(sprite_x),
        .sprite_y(sprite_y), .sprite_flip(sprite_flip), .sprite_en(sprite_en),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .bg_rom_addr(bg_rom_addr), .bg_rom_q(bg_rom_q),
        .spr_rom_addr(spr_rom_addr), .spr_rom_q(spr_rom_q),
        .red(red), .green(green), .blue(blue)
    );

    always #5 vga_clk = ~vga_clk;

    // Synchronous ROMs with one cycle of read latency.
    always @(posedge vga_clk) begin
        bg_rom_q  <= bgMem[bg_rom_addr];
        spr_rom_q <= sprMem[spr_rom_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit modelHit(input int x, input int y);
        int dx = x - mActX;
        int dy = y - mActY;
        return mActEn && dx >= 0 && dy >= 0 && dx < 32 && dy < 32;
    endfunction

    function automatic int modelSprAddr(input int x, input int y);
        int col = (x - mActX) / 2;
        int row = (y - mActY) / 2;
        if (mActFlip) col = 15 - col;
        return ((mFs / 8) % 4) * 256 + row * 16 + col;
    endfunction

    function automatic void modelReset();
        mActX = 0; mActY = 0; mActFlip = 0; mActEn = 0; mFs = 0;
        for (int i = 0; i < 16; i++) mPal[i] = 12'h000;
        prevBlank = 0;
        prevIdx   = 0;
    endfunction

    // One pixel per call: drive, predict, then compare the pixel from the previous call.
    task automatic applyStimulus(input int x, input int y, input bit bl, input bit fs,
                                 input bit we, input logic [3:0] wa, input logic [11:0] wd);
        bit          hit;
        int          sAddr;
        int          bAddr;
        logic [3:0]  curIdx;
        logic [11:0] expRgb;
        @(negedge vga_clk);
        DrawX = 10'(x); DrawY = 10'(y); blank = bl; frame_start = fs;
        pal_we = we; pal_addr = wa; pal_data = wd;
        #1;
        bAddr = (y / 16) * 40 + x / 16;
        hit   = modelHit(x, y);
        sAddr = hit ? modelSprAddr(x, y) : 0;
        checkOutput("bg_addr", 32'(bg_rom_addr), 32'(bAddr));
        checkOutput("spr_addr", 32'(spr_rom_addr), 32'(sAddr));
        curIdx = (hit && sprMem[sAddr] != 4'd0) ? sprMem[sAddr] : bgMem[bAddr];
        expRgb = prevBlank ? mPal[prevIdx] : 12'h000;
        if (we) mPal[wa] = wd;
        if (fs) begin
            mActX = int'(sprite_x); mActY = int'(sprite_y);
            mActFlip = sprite_flip; mActEn = sprite_en;
            mFs++;
        end
        prevBlank = bl;
        prevIdx   = curIdx;
        @(posedge vga_clk);
        #1;
        checkOutput("rgb", 32'({red, green, blue}), 32'(expRgb));
    endtask

    task automatic idle();
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000);
    endtask

    task automatic pixel(input int x, input int y);
        applyStimulus(x, y, 1'b1, 1'b0, 1'b0, 4'd0, 12'h000);
    endtask

    task automatic doReset();
        @(negedge vga_clk);
        #2 reset_n = 1'b0;
        #1 checkOutput("reset_async", 32'({red, green, blue}), 32'h0);
        modelReset();
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1;
    endtask

    task automatic writeRandomPalette();
        for (int i = 0; i < 16; i++)
            applyStimulus(0, 0, 1'b0, 1'b0, 1'b1, 4'(i), 12'($urandom));
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b1, 4'd3, 12'hF80);
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b1, 4'd5, 12'h05A);
    endtask

    initial begin
        int x, y;
        bit fs, we;
        for (int i = 0; i < 2048; i++) bgMem[i] = 4'($urandom);
        for (int i = 0; i < 1024; i++) sprMem[i] = 4'($urandom);
        for (int i = 126; i <= 128; i++) bgMem[i] = 4'd3;
        bgMem[0]  = 4'd3;
        sprMem[1] = 4'd0;
        sprMem[2] = 4'd5;
        modelReset();

        repeat (3) begin
            @(posedge vga_clk);
            #1 checkOutput("reset_rgb", 32'({red, green, blue}), 32'h0);
        end
        @(negedge vga_clk);
        reset_n = 1'b1;

        pixel(0, 0);
        idle();
        checkOutput("rgb_pal_zero", 32'({red, green, blue}), 32'h0);

        writeRandomPalette();
        pixel(0, 0);
        idle();
        checkOutput("rgb_pal3", 32'({red, green, blue}), 32'hF80);
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000);
        idle();
        checkOutput("rgb_blanked", 32'({red, green, blue}), 32'h0);

        sprite_x = 10'd100; sprite_y = 10'd50; sprite_en = 1'b1; sprite_flip = 1'b0;
        applyStimulus(100, 50, 1'b1, 1'b1, 1'b0, 4'd0, 12'h000);
        pixel(100, 50);
        checkOutput("spr_tl", 32'(spr_rom_addr), 32'd0);
        pixel(131, 50);
        checkOutput("spr_right", 32'(spr_rom_addr), 32'd15);
        pixel(132, 50);
        checkOutput("spr_miss_addr", 32'(spr_rom_addr), 32'd0);
        idle();
        checkOutput("spr_miss_bg", 32'({red, green, blue}), 32'hF80);
        pixel(102, 50);
        idle();
        checkOutput("transparent", 32'({red, green, blue}), 32'hF80);
        pixel(104, 50);
        idle();
        checkOutput("opaque", 32'({red, green, blue}), 32'h05A);

        sprite_flip = 1'b1;
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, 4'd0, 12'h000);
        pixel(100, 50);
        checkOutput("flip_tl", 32'(spr_rom_addr), 32'd15);
        sprite_x = 10'd200;
        pixel(100, 50);
        checkOutput("shadow_hold", 32'(spr_rom_addr), 32'd15);

        sprite_x = 10'd100; sprite_flip = 1'b0;
        repeat (6) applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, 4'd0, 12'h000);
        pixel(100, 50);
        checkOutput("anim_base1", 32'(spr_rom_addr), 32'd256);
        repeat (24) applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, 4'd0, 12'h000);
        pixel(100, 50);
        checkOutput("anim_wrap", 32'(spr_rom_addr), 32'd0);

        pixel(104, 50);
        doReset();
        pixel(0, 0);
        pixel(104, 50);
        idle();
        checkOutput("post_reset_rgb", 32'({red, green, blue}), 32'h0);

        writeRandomPalette();
        for (int n = 0; n < 2500; n++) begin
            if (n % 100 == 0) begin
                sprite_x    = 10'($urandom_range(0, 620));
                sprite_y    = 10'($urandom_range(0, 470));
                sprite_flip = 1'($urandom);
                sprite_en   = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 1) == 0) begin
                x = mActX + int'($urandom_range(0, 40)) - 4;
                y = mActY + int'($urandom_range(0, 40)) - 4;
            end else begin
                x = int'($urandom_range(0, 639));
                y = int'($urandom_range(0, 479));
            end
            if (x < 0) x = 0;
            if (x > 639) x = 639;
            if (y < 0) y = 0;
            if (y > 479) y = 479;
            fs = ($urandom_range(0, 39) == 0);
            we = ($urandom_range(0, 14) == 0);
            applyStimulus(x, y, ($urandom_range(0, 7) != 0), fs, we, 4'($urandom), 12'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
